eye_tracker_host_if: RTL



---
 rtl/eye_tracker_host_pkg.sv | 19 +
 rtl/eye_tracker_host_if.sv | 131 +++++++++++++
 2 files changed

// File: rtl/eye_tracker_host_pkg.sv
// Shared definitions for the EyeTracker host command bridge: opcodes, FSM
// encoding, error counter width and default write-data timeout.
package eye_tracker_host_pkg;

  localparam logic [3:0] OP_WRITE = 4'hA;
  localparam logic [3:0] OP_READ  = 4'h5;

  localparam int ERR_CNT_WIDTH          = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_TX    = 3'd4
  } state_e;

endpackage

// File: rtl/eye_tracker_host_if.sv
// Parses UART command bytes into one-hot register write/read strobes and
// returns read data to the UART transmitter, counting protocol errors.
module eye_tracker_host_if
  import eye_tracker_host_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int WE_WIDTH       = 4,
  parameter int RE_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     iRX_VALID,
  input  logic [DATA_WIDTH-1:0]    iRX_DATA,
  output logic                     oTX_VALID,
  output logic [DATA_WIDTH-1:0]    oTX_DATA,
  input  logic                     iTX_READY,
  output logic [WE_WIDTH-1:0]      oWE_BIT,
  output logic [RE_WIDTH-1:0]      oRE_BIT,
  output logic [DATA_WIDTH-1:0]    oDATA,
  input  logic [DATA_WIDTH-1:0]    iRD,
  output logic [ERR_CNT_WIDTH-1:0] oERR_CNT,
  output logic                     oBUSY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [1:0]               addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

  logic                     err_inc;
  logic                     cmd_write, cmd_read;
  logic [WE_WIDTH-1:0]      we;
  logic [RE_WIDTH-1:0]      re;
  logic                     tx_valid;

  assign cmd_write = (iRX_DATA[7:4] == OP_WRITE) && (iRX_DATA[3:2] == 2'b00);
  assign cmd_read  = (iRX_DATA[7:4] == OP_READ)  && (iRX_DATA[3:2] == 2'b00);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_data_d = tx_data_q;
    timer_d   = timer_q;
    err_inc   = 1'b0;
    we        = '0;
    re        = '0;
    tx_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (iRX_VALID) begin
          if (cmd_write) begin
            state_d = ST_WDATA;
            addr_d  = iRX_DATA[1:0];
            timer_d = '0;
          end else if (cmd_read) begin
            state_d = ST_READ;
            addr_d  = iRX_DATA[1:0];
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      // A data byte arriving in the expiry cycle takes priority over timeout
      ST_WDATA: begin
        if (iRX_VALID) begin
          data_d  = iRX_DATA;
          state_d = ST_WRITE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_IDLE;
          err_inc = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WRITE: begin
        we[addr_q] = 1'b1;
        err_inc    = iRX_VALID;
        state_d    = ST_IDLE;
      end
      ST_READ: begin
        re[addr_q] = 1'b1;
        tx_data_d  = iRD;
        err_inc    = iRX_VALID;
        state_d    = ST_TX;
      end
      ST_TX: begin
        tx_valid = 1'b1;
        err_inc  = iRX_VALID;
        if (iTX_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = (err_inc && (err_q != '1)) ? err_q + ERR_CNT_WIDTH'(1) : err_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      tx_data_q <= '0;
      timer_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tx_data_q <= tx_data_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
    end
  end

  assign oWE_BIT   = we;
  assign oRE_BIT   = re;
  assign oDATA     = data_q;
  assign oTX_VALID = tx_valid;
  assign oTX_DATA  = tx_data_q;
  assign oERR_CNT  = err_q;
  assign oBUSY     = (state_q != ST_IDLE);

endmodule
